seg_display_scheduler: RTL and testbench

- Time-shares the single 4-digit hex display among NUM_REQ independent requesters, e.g. a debug counter, FSM state and error code.
- Grants are round-robin, and each grant lasts a guaranteed minimum of HOLD_CYCLES clocks.
- Output disp_value drives the value input of the hex seven-segment driver; owner/owner_valid can drive LEDs showing the current source.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_display_scheduler_if.sv | 26 ++
 rtl/rr_pick.sv | 32 +++
 rtl/seg_display_scheduler.sv | 124 ++++++++++++
 tb/tb_seg_display_scheduler.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg_pkg;

    typedef enum logic {
        IDLE,
        SHOW
    } state_e;

    localparam int DIGITS_W            = 16;
    localparam int HOLD_CYCLES_DEFAULT = 100_000_000;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Requester/display bus between the requesters, the scheduler and the hex display driver.
interface seg_display_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    import seg_pkg::*;

    logic [NUM_REQ-1:0]          req_valid;
    logic [DIGITS_W*NUM_REQ-1:0] req_value;
    logic [DIGITS_W-1:0]         idle_value;
    logic [NUM_REQ-1:0]          req_ack;
    logic [DIGITS_W-1:0]         disp_value;
    logic [IDX_W-1:0]            owner;
    logic                        owner_valid;

    modport master (
        output req_valid, req_value, idle_value,
        input  req_ack, disp_value, owner, owner_valid
    );

    modport slave (
        input  req_valid, req_value, idle_value,
        output req_ack, disp_value, owner, owner_valid
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request above ptr_i, wrapping,
// optionally skipping one excluded index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               excl_en_i,
    input  logic [IDX_W-1:0]   excl_idx_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   winner_o
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        cand     = '0;
        // Scan farthest-first so the nearest eligible slot after ptr_i overwrites last and wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (req_i[cand] && !(excl_en_i && (cand == excl_idx_i))) begin
                found_o  = 1'b1;
                winner_o = cand;
            end
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of one 4-digit hex display with a minimum hold per grant.
// Define SEG_SCHED_PREEMPT_EN to let requester 0 preempt any other owner.
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter int CNT_W       = 27,
    parameter int IDX_W       = clog2(NUM_REQ)
) (
    input logic                    clk,
    input logic                    reset,
    seg_display_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                owner_valid_q, owner_valid_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [DIGITS_W-1:0] disp_q, disp_d;

    logic [DIGITS_W-1:0] req_val_a [NUM_REQ];
    logic                pick_found;
    logic [IDX_W-1:0]    pick_winner;
    logic                preempt, expired, owner_req;
    logic                grant, hold_again, go_idle;
    logic [IDX_W-1:0]    grant_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_val
        assign req_val_a[g] = bus.req_value[DIGITS_W*g +: DIGITS_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i      (bus.req_valid),
        .ptr_i      (rr_ptr_q),
        .excl_en_i  (state_q == SHOW),
        .excl_idx_i (owner_q),
        .found_o    (pick_found),
        .winner_o   (pick_winner)
    );

`ifdef SEG_SCHED_PREEMPT_EN
    assign preempt = (state_q == SHOW) && (owner_q != '0) && bus.req_valid[0];
`else
    assign preempt = 1'b0;
`endif

    assign expired    = (hold_cnt_q == '0);
    assign owner_req  = bus.req_valid[owner_q];
    assign grant      = preempt || (pick_found && ((state_q == IDLE) || expired));
    assign grant_idx  = preempt ? '0 : pick_winner;
    assign hold_again = (state_q == SHOW) && expired && !grant && owner_req;
    assign go_idle    = (state_q == SHOW) && expired && !grant && !owner_req;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            ack_q         <= '0;
            disp_q        <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            ack_q         <= ack_d;
            disp_q        <= disp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant)   state_d = SHOW;
            SHOW:    if (go_idle) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_d    = hold_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        ack_d         = '0;
        disp_d        = disp_q;
        if (grant) begin
            hold_cnt_d    = HOLD_RELOAD;
            rr_ptr_d      = grant_idx;
            owner_d       = grant_idx;
            owner_valid_d = 1'b1;
            ack_d         = NUM_REQ'(1) << grant_idx;
            disp_d        = req_val_a[grant_idx];
        end else if (state_q == IDLE || go_idle) begin
            owner_d       = '0;
            owner_valid_d = 1'b0;
            disp_d        = bus.idle_value;
        end else begin
            hold_cnt_d = hold_again ? HOLD_RELOAD
                                    : (expired ? hold_cnt_q : hold_cnt_q - CNT_ONE);
            // A requester that drops its valid leaves its last value frozen on the display.
            if (owner_req) disp_d = req_val_a[owner_q];
        end
    end

    assign bus.req_ack     = ack_q;
    assign bus.disp_value  = disp_q;
    assign bus.owner       = owner_q;
    assign bus.owner_valid = owner_valid_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler: directed scenarios plus randomized
// traffic against a behavioural model (honours SEG_SCHED_PREEMPT_EN).
module tb_seg_display_scheduler;

    localparam int NUM_REQ = 4;
    localparam int HOLD    = 4;
    localparam int CNT_W   = 27;
    localparam int IDX_W   = 2;

    logic clk;
    logic reset;
    int   n_run;
    int   n_fail;

    int          m_owner;
    int          m_shown;
    int          m_ptr;
    logic [15:0] m_disp;
    logic [3:0]  m_ack;

    seg_display_scheduler_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

    seg_display_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CNT_W),
        .IDX_W       (IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] v, input int ptr, input int excl);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (ptr + k) % NUM_REQ;
            if (v[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_shown = 0;
        m_ptr   = NUM_REQ - 1;
        m_disp  = 16'h0000;
        m_ack   = 4'b0000;
    endtask

    // m_shown counts edges the current owner has been displayed; the grant may move once it reaches HOLD.
    task automatic model_step(input logic [3:0] v, input logic [63:0] vals, input logic [15:0] idle);
        int   w;
        logic pre;
        m_ack = 4'b0000;
        pre   = 1'b0;
`ifdef SEG_SCHED_PREEMPT_EN
        pre = (m_owner > 0) && v[0];
`endif
        if (m_owner < 0)           w = pick(v, m_ptr, -1);
        else if (pre)              w = 0;
        else if (m_shown >= HOLD)  w = pick(v, m_ptr, m_owner);
        else                       w = -1;

        if (w >= 0) begin
            m_owner = w;
            m_shown = 1;
            m_ptr   = w;
            m_ack   = 4'(1 << w);
            m_disp  = vals[16*w +: 16];
        end else if (m_owner < 0) begin
            m_disp = idle;
        end else if (m_shown >= HOLD && !v[m_owner]) begin
            m_owner = -1;
            m_disp  = idle;
        end else begin
            m_shown = (m_shown >= HOLD) ? 1 : m_shown + 1;
            if (v[m_owner]) m_disp = vals[16*m_owner +: 16];
        end
    endtask

    task automatic tick(input logic [3:0] v, input logic [63:0] vals, input logic [15:0] idle);
        bus.req_valid  = v;
        bus.req_value  = vals;
        bus.idle_value = idle;
        model_step(v, vals, idle);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] idle);
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_value  = '0;
        bus.idle_value = idle;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_value  = '0;
        bus.idle_value = 16'hBEEF;
        model_reset();
        @(posedge clk);
        #1;
        n_run++;
        if ({bus.req_ack, bus.owner, bus.owner_valid, bus.disp_value} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_values: got ack=%b owner=%0d ov=%b disp=%h, want all zero",
                     bus.req_ack, bus.owner, bus.owner_valid, bus.disp_value);
        end
        reset = 1'b0;
        tick(4'b0000, 64'h0, 16'hBEEF);
        n_run++;
        if (bus.disp_value !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL idle_after_reset disp: got %h want beef", bus.disp_value);
        end
        n_run++;
        if ({bus.owner_valid, bus.req_ack} !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset ov/ack: got ov=%b ack=%b want 0/0000", bus.owner_valid, bus.req_ack);
        end
    endtask

    task automatic test_single_grant();
        do_reset(16'h0F0F);
        tick(4'b0100, {16'h0, 16'h1234, 16'h0, 16'h0}, 16'h0F0F);
        n_run++;
        if ({bus.req_ack, bus.owner, bus.owner_valid, bus.disp_value} !== {4'b0100, 2'd2, 1'b1, 16'h1234}) begin
            n_fail++;
            $display("FAIL single_grant: got ack=%b owner=%0d ov=%b disp=%h want 0100/2/1/1234",
                     bus.req_ack, bus.owner, bus.owner_valid, bus.disp_value);
        end
        tick(4'b0100, {16'h0, 16'h1235, 16'h0, 16'h0}, 16'h0F0F);
        n_run++;
        if ({bus.req_ack, bus.disp_value} !== {4'b0000, 16'h1235}) begin
            n_fail++;
            $display("FAIL live_tracking: got ack=%b disp=%h want 0000/1235", bus.req_ack, bus.disp_value);
        end
    endtask

    task automatic test_round_robin();
        do_reset(16'h0000);
        for (int t = 1; t <= 9; t++) begin
            int eo;
            int ea;
            eo = ((t - 1) / HOLD) % 2;
            ea = ((t - 1) % HOLD == 0) ? (1 << eo) : 0;
            tick(4'b0011, {16'h0, 16'h0, 16'hB111, 16'hA000}, 16'h0000);
            n_run++;
            if ({bus.owner, bus.req_ack, bus.owner_valid} !== {2'(eo), 4'(ea), 1'b1}) begin
                n_fail++;
                $display("FAIL round_robin cycle %0d: got owner=%0d ack=%b ov=%b want %0d/%b/1",
                         t, bus.owner, bus.req_ack, bus.owner_valid, eo, 4'(ea));
            end
        end
    endtask

    task automatic test_freeze_release();
        do_reset(16'hCAFE);
        tick(4'b0010, {16'h0, 16'h0, 16'hAAAA, 16'h0}, 16'hCAFE);
        for (int t = 2; t <= HOLD; t++) begin
            tick(4'b0000, {16'h0, 16'h0, 16'hBBBB, 16'h0}, 16'hCAFE);
            n_run++;
            if ({bus.owner_valid, bus.owner, bus.disp_value} !== {1'b1, 2'd1, 16'hAAAA}) begin
                n_fail++;
                $display("FAIL freeze cycle %0d: got ov=%b owner=%0d disp=%h want 1/1/aaaa",
                         t, bus.owner_valid, bus.owner, bus.disp_value);
            end
        end
        tick(4'b0000, {16'h0, 16'h0, 16'hBBBB, 16'h0}, 16'hCAFE);
        n_run++;
        if ({bus.owner_valid, bus.owner, bus.req_ack, bus.disp_value} !== {1'b0, 2'd0, 4'b0000, 16'hCAFE}) begin
            n_fail++;
            $display("FAIL release_to_idle: got ov=%b owner=%0d ack=%b disp=%h want 0/0/0000/cafe",
                     bus.owner_valid, bus.owner, bus.req_ack, bus.disp_value);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset(16'h1111);
        tick(4'b0001, {48'h0, 16'h5A5A}, 16'h1111);
        tick(4'b0001, {48'h0, 16'h5A5A}, 16'h1111);
        reset = 1'b1;
        #1;
        n_run++;
        if ({bus.req_ack, bus.owner, bus.owner_valid, bus.disp_value} !== 23'd0) begin
            n_fail++;
            $display("FAIL async_reset: got ack=%b owner=%0d ov=%b disp=%h want all zero",
                     bus.req_ack, bus.owner, bus.owner_valid, bus.disp_value);
        end
        @(posedge clk);
        #1;
        n_run++;
        if ({bus.req_ack, bus.owner_valid} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_hold_no_ack: got ack=%b ov=%b want 0000/0", bus.req_ack, bus.owner_valid);
        end
        reset = 1'b0;
    endtask

    task automatic test_preempt();
        do_reset(16'h0000);
        tick(4'b1000, {16'h3333, 32'h0, 16'h0101}, 16'h0000);
        n_run++;
        if ({bus.owner, bus.req_ack} !== {2'd3, 4'b1000}) begin
            n_fail++;
            $display("FAIL preempt_setup: got owner=%0d ack=%b want 3/1000", bus.owner, bus.req_ack);
        end
`ifdef SEG_SCHED_PREEMPT_EN
        tick(4'b1001, {16'h3333, 32'h0, 16'h0101}, 16'h0000);
        n_run++;
        if ({bus.owner, bus.req_ack, bus.disp_value} !== {2'd0, 4'b0001, 16'h0101}) begin
            n_fail++;
            $display("FAIL preempt_grant: got owner=%0d ack=%b disp=%h want 0/0001/0101",
                     bus.owner, bus.req_ack, bus.disp_value);
        end
`else
        for (int t = 1; t < HOLD; t++) begin
            tick(4'b1001, {16'h3333, 32'h0, 16'h0101}, 16'h0000);
            n_run++;
            if ({bus.owner, bus.req_ack} !== {2'd3, 4'b0000}) begin
                n_fail++;
                $display("FAIL no_preempt cycle %0d: got owner=%0d ack=%b want 3/0000", t, bus.owner, bus.req_ack);
            end
        end
        tick(4'b1001, {16'h3333, 32'h0, 16'h0101}, 16'h0000);
        n_run++;
        if ({bus.owner, bus.req_ack, bus.disp_value} !== {2'd0, 4'b0001, 16'h0101}) begin
            n_fail++;
            $display("FAIL expiry_switch: got owner=%0d ack=%b disp=%h want 0/0001/0101",
                     bus.owner, bus.req_ack, bus.disp_value);
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0]  v;
        logic [63:0] vals;
        logic [15:0] idle;
        logic [22:0] exp_v;
        logic [22:0] act_v;
        do_reset(16'h0000);
        v = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < NUM_REQ; b++) begin
                if ($urandom_range(5) == 0) v[b] = ~v[b];
            end
            vals = {$urandom, $urandom};
            idle = 16'($urandom);
            tick(v, vals, idle);
            exp_v = {m_ack, 2'(m_owner < 0 ? 0 : m_owner), m_owner >= 0, m_disp};
            act_v = {bus.req_ack, bus.owner, bus.owner_valid, bus.disp_value};
            n_run++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL random cycle %0d: got ack=%b owner=%0d ov=%b disp=%h want ack=%b owner=%0d ov=%b disp=%h",
                         c, act_v[22:19], act_v[18:17], act_v[16], act_v[15:0],
                         exp_v[22:19], exp_v[18:17], exp_v[16], exp_v[15:0]);
            end
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        reset  = 1'b1;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_freeze_release();
        test_reset_mid_grant();
        test_preempt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
